// File: rtl/urv_irq_ctrl_pkg.sv
// rtl/urv_irq_ctrl_pkg.sv - shared register map, TCTRL layout and claim helpers for urv_irq_ctrl
package urv_irq_ctrl_pkg;

    localparam logic [2:0] IRQC_REG_PENDING = 3'd0;
    localparam logic [2:0] IRQC_REG_ENABLE  = 3'd1;
    localparam logic [2:0] IRQC_REG_EDGE    = 3'd2;
    localparam logic [2:0] IRQC_REG_CLAIM   = 3'd3;
    localparam logic [2:0] IRQC_REG_TCNT    = 3'd4;
    localparam logic [2:0] IRQC_REG_TCMP    = 3'd5;
    localparam logic [2:0] IRQC_REG_TCTRL   = 3'd6;

    localparam int IRQC_TCTRL_RUN        = 0;
    localparam int IRQC_TCTRL_AUTORELOAD = 1;

    typedef struct packed {
        logic autoreload;
        logic run;
    } irqc_tctrl_t;

    // Index+1 of the lowest set bit, 0 when nothing is set.
    function automatic logic [31:0] irqc_claim_id(input logic [31:0] v);
        logic [31:0] id;
        id = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) id = 32'(i + 1);
        end
        return id;
    endfunction

    function automatic logic [31:0] irqc_lowest_bit(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/urv_irq_timer.sv
// rtl/urv_irq_timer.sv - TCNT/TCMP/TCTRL timer with one-cycle compare tick
module urv_irq_timer
    import urv_irq_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tcnt_we_i,
    input  logic        tcmp_we_i,
    input  logic        tctrl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tcnt_o,
    output logic [31:0] tcmp_o,
    output logic [1:0]  tctrl_o,
    output logic        tick_o
);

    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    irqc_tctrl_t tctrl_q, tctrl_d;
    logic        tick_q, tick_d;
    logic        hit;

    always_comb begin
        hit    = tctrl_q.run && (tcnt_q == tcmp_q);
        tick_d = hit;

        tcnt_d = tcnt_q;
        if (tcnt_we_i) begin
            tcnt_d = wdata_i;
        end else if (tctrl_q.run) begin
            tcnt_d = (hit && tctrl_q.autoreload) ? 32'd0 : tcnt_q + 32'd1;
        end

        tcmp_d = tcmp_we_i ? wdata_i : tcmp_q;

        tctrl_d = tctrl_q;
        if (tctrl_we_i) begin
            tctrl_d.run        = wdata_i[IRQC_TCTRL_RUN];
            tctrl_d.autoreload = wdata_i[IRQC_TCTRL_AUTORELOAD];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tcnt_q  <= '0;
            tcmp_q  <= '0;
            tctrl_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            tctrl_q <= tctrl_d;
            tick_q  <= tick_d;
        end
    end

    assign tcnt_o  = tcnt_q;
    assign tcmp_o  = tcmp_q;
    assign tctrl_o = tctrl_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/urv_irq_ctrl.sv
// rtl/urv_irq_ctrl.sv - interrupt source controller feeding exp_irq_i/exp_tick_i of the exception unit
module urv_irq_ctrl
    import urv_irq_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [2:0]       bus_addr_i,
    input  logic [31:0]      bus_wdata_i,
    input  logic             bus_we_i,
    input  logic             bus_re_i,
    output logic [31:0]      bus_rdata_o,
    output logic             bus_ready_o,
    output logic [31:0]      exp_irq_o,
    output logic             exp_tick_o
);

    localparam logic [31:0] IRQ_MASK = (N_IRQ >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << N_IRQ) - 32'd1);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] sync_d [SYNC_STAGES];
    logic [N_IRQ-1:0] irq_dly_q, irq_dly_d;

    logic [31:0] pending_q, pending_d;
    logic [31:0] enable_q, enable_d;
    logic [31:0] trig_edge_q, trig_edge_d;
    logic [31:0] exp_irq_q, exp_irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;

    logic [31:0] irq_sync, irq_prev, irq_rise;
    logic [31:0] active, claim_id, claim_clr, w1c_clr;
    logic [31:0] tcnt, tcmp;
    logic [1:0]  tctrl;
    logic        tick;

    always_comb begin
        sync_d[0] = irq_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        irq_dly_d = sync_q[SYNC_STAGES-1];

        irq_sync = '0;
        irq_prev = '0;
        irq_sync[N_IRQ-1:0] = sync_q[SYNC_STAGES-1];
        irq_prev[N_IRQ-1:0] = irq_dly_q;
        irq_rise = irq_sync & ~irq_prev;
    end

    always_comb begin
        active    = pending_q & enable_q;
        claim_id  = irqc_claim_id(active);
        claim_clr = '0;
        if (bus_re_i && bus_addr_i == IRQC_REG_CLAIM) begin
            claim_clr = irqc_lowest_bit(active) & trig_edge_q;
        end
        w1c_clr = (bus_we_i && bus_addr_i == IRQC_REG_PENDING) ? bus_wdata_i : 32'd0;

        // Edge lines: a new rising edge beats any clear in the same cycle.
        // Level lines simply mirror the synchronised input.
        pending_d = ((((pending_q & ~(w1c_clr | claim_clr)) | irq_rise) & trig_edge_q)
                    | (irq_sync & ~trig_edge_q)) & IRQ_MASK;

        enable_d    = enable_q;
        trig_edge_d = trig_edge_q;
        if (bus_we_i && bus_addr_i == IRQC_REG_ENABLE) enable_d    = bus_wdata_i & IRQ_MASK;
        if (bus_we_i && bus_addr_i == IRQC_REG_EDGE)   trig_edge_d = bus_wdata_i & IRQ_MASK;

        exp_irq_d = active;
        ready_d   = bus_re_i | bus_we_i;

        rdata_d = '0;
        if (bus_re_i) begin
            case (bus_addr_i)
                IRQC_REG_PENDING: rdata_d = pending_q;
                IRQC_REG_ENABLE:  rdata_d = enable_q;
                IRQC_REG_EDGE:    rdata_d = trig_edge_q;
                IRQC_REG_CLAIM:   rdata_d = claim_id;
                IRQC_REG_TCNT:    rdata_d = tcnt;
                IRQC_REG_TCMP:    rdata_d = tcmp;
                IRQC_REG_TCTRL:   rdata_d = {30'd0, tctrl};
                default:          rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            irq_dly_q   <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            trig_edge_q <= '0;
            exp_irq_q   <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            irq_dly_q   <= irq_dly_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            trig_edge_q <= trig_edge_d;
            exp_irq_q   <= exp_irq_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    urv_irq_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tcnt_we_i  (bus_we_i && bus_addr_i == IRQC_REG_TCNT),
        .tcmp_we_i  (bus_we_i && bus_addr_i == IRQC_REG_TCMP),
        .tctrl_we_i (bus_we_i && bus_addr_i == IRQC_REG_TCTRL),
        .wdata_i    (bus_wdata_i),
        .tcnt_o     (tcnt),
        .tcmp_o     (tcmp),
        .tctrl_o    (tctrl),
        .tick_o     (tick)
    );

    assign bus_rdata_o = rdata_q;
    assign bus_ready_o = ready_q;
    assign exp_irq_o   = exp_irq_q;
    assign exp_tick_o  = tick;

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// tb/tb_urv_irq_ctrl.sv - directed self-checking bench for urv_irq_ctrl
module tb_urv_irq_ctrl;
    import urv_irq_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] irq_i;
    logic [2:0]  bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic        bus_we_i;
    logic        bus_re_i;
    logic [31:0] bus_rdata_o;
    logic        bus_ready_o;
    logic [31:0] exp_irq_o;
    logic        exp_tick_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [11];

    urv_irq_ctrl #(.N_IRQ(32), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_i       (irq_i),
        .bus_addr_i  (bus_addr_i),
        .bus_wdata_i (bus_wdata_i),
        .bus_we_i    (bus_we_i),
        .bus_re_i    (bus_re_i),
        .bus_rdata_o (bus_rdata_o),
        .bus_ready_o (bus_ready_o),
        .exp_irq_o   (exp_irq_o),
        .exp_tick_o  (exp_tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_xfer(input logic we, input logic re, input logic [2:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic rdy);
        bus_we_i    = we;
        bus_re_i    = re;
        bus_addr_i  = addr;
        bus_wdata_i = wd;
        @(posedge clk_i);
        #1;
        rd       = bus_rdata_o;
        rdy      = bus_ready_o;
        bus_we_i = 1'b0;
        bus_re_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic        r;
        bus_xfer(1'b1, 1'b0, addr, wd, d, r);
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] d);
        logic r;
        bus_xfer(1'b0, 1'b1, addr, 32'd0, d, r);
    endtask

    initial begin
        logic [31:0] d;
        logic        r;
        int          first;
        int          nt;
        int          t [4];
        int          width_err;
        logic        prev;

        vecs[0]  = '{IRQC_REG_ENABLE,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1]  = '{IRQC_REG_EDGE,    32'h0000_A5A5, 32'h0000_A5A5};
        vecs[2]  = '{IRQC_REG_TCMP,    32'h1234_5678, 32'h1234_5678};
        vecs[3]  = '{IRQC_REG_TCNT,    32'h0000_0055, 32'h0000_0055};
        vecs[4]  = '{IRQC_REG_TCTRL,   32'hFFFF_FFFF, 32'h0000_0003};
        vecs[5]  = '{IRQC_REG_TCTRL,   32'h0000_0000, 32'h0000_0000};
        vecs[6]  = '{3'd7,             32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{IRQC_REG_CLAIM,   32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{IRQC_REG_PENDING, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{IRQC_REG_ENABLE,  32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{IRQC_REG_EDGE,    32'h0000_0000, 32'h0000_0000};

        rst_i = 1'b0; irq_i = '0; bus_addr_i = '0; bus_wdata_i = '0;
        bus_we_i = 1'b0; bus_re_i = 1'b0;
        cyc(3);
        check("rst_exp_irq", exp_irq_o, 32'd0);
        check("rst_tick", {31'd0, exp_tick_o}, 32'd0);
        check("rst_ready", {31'd0, bus_ready_o}, 32'd0);
        check("rst_rdata", bus_rdata_o, 32'd0);
        rst_i = 1'b1;
        cyc(1);
        rd(IRQC_REG_TCNT, d);
        check("rst_tcnt", d, 32'd0);
        rd(IRQC_REG_PENDING, d);
        check("rst_pending", d, 32'd0);
        cyc(1);
        check("idle_ready", {31'd0, bus_ready_o}, 32'd0);
        check("idle_rdata", bus_rdata_o, 32'd0);

        foreach (vecs[i]) begin
            bus_xfer(1'b1, 1'b0, vecs[i].addr, vecs[i].wdata, d, r);
            check($sformatf("vec%0d_wr_ready", i), {31'd0, r}, 32'd1);
            rd(vecs[i].addr, d);
            check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
        end

        // Edge line 0
        wr(IRQC_REG_EDGE, 32'h1);
        wr(IRQC_REG_ENABLE, 32'h1);
        irq_i = 32'h1;
        cyc(1);
        irq_i = 32'h0;
        cyc(2);
        check("edge_exp_early", exp_irq_o, 32'h0);
        cyc(1);
        check("edge_exp_set", exp_irq_o, 32'h1);
        rd(IRQC_REG_CLAIM, d);
        check("edge_claim", d, 32'd1);
        rd(IRQC_REG_PENDING, d);
        check("edge_pend_clr", d, 32'h0);
        check("edge_exp_clr", exp_irq_o, 32'h0);

        // Level line 2
        wr(IRQC_REG_EDGE, 32'h0);
        wr(IRQC_REG_ENABLE, 32'h4);
        irq_i = 32'h4;
        cyc(5);
        check("lvl_exp_set", exp_irq_o, 32'h4);
        wr(IRQC_REG_PENDING, 32'h4);
        rd(IRQC_REG_PENDING, d);
        check("lvl_w1c_ignored", d, 32'h4);
        irq_i = 32'h0;
        cyc(3);
        check("lvl_exp_hold", exp_irq_o, 32'h4);
        cyc(1);
        check("lvl_exp_drop", exp_irq_o, 32'h0);

        // Priority and mask on edge lines 3 and 5
        wr(IRQC_REG_EDGE, 32'hFFFF_FFFF);
        wr(IRQC_REG_ENABLE, 32'h20);
        irq_i = 32'h28;
        cyc(1);
        irq_i = 32'h0;
        cyc(5);
        check("prio_exp", exp_irq_o, 32'h20);
        rd(IRQC_REG_CLAIM, d);
        check("prio_claim6", d, 32'd6);
        wr(IRQC_REG_ENABLE, 32'h28);
        rd(IRQC_REG_CLAIM, d);
        check("prio_claim4", d, 32'd4);
        rd(IRQC_REG_CLAIM, d);
        check("prio_claim_none", d, 32'd0);

        // Simultaneous read and write returns the pre-write value
        bus_xfer(1'b1, 1'b1, IRQC_REG_ENABLE, 32'h3, d, r);
        check("rw_pre_value", d, 32'h28);
        check("rw_ready", {31'd0, r}, 32'd1);
        rd(IRQC_REG_ENABLE, d);
        check("rw_post_value", d, 32'h3);

        // Rising edge on line 1 lands in the same cycle as its W1C
        irq_i = 32'h2;
        cyc(1);
        irq_i = 32'h0;
        cyc(1);
        wr(IRQC_REG_PENDING, 32'h2);
        rd(IRQC_REG_PENDING, d);
        check("race_set_wins", d, 32'h2);
        wr(IRQC_REG_PENDING, 32'h2);
        rd(IRQC_REG_PENDING, d);
        check("race_w1c", d, 32'h0);

        // Timer autoreload, period TCMP+1
        wr(IRQC_REG_TCNT, 32'd0);
        wr(IRQC_REG_TCMP, 32'd9);
        wr(IRQC_REG_TCTRL, 32'h3);
        nt = 0; width_err = 0; prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (exp_tick_o) begin
                if (prev) width_err++;
                if (nt < 4) t[nt] = c;
                nt++;
            end
            prev = exp_tick_o;
        end
        check("tick_count", 32'(nt), 32'd4);
        check("tick_width", 32'(width_err), 32'd0);
        check("tick_first", 32'(t[0]), 32'd9);
        check("tick_period1", 32'(t[1] - t[0]), 32'd10);
        check("tick_period2", 32'(t[2] - t[1]), 32'd10);

        // Timer wrap, no autoreload
        wr(IRQC_REG_TCTRL, 32'h0);
        wr(IRQC_REG_TCMP, 32'd3);
        wr(IRQC_REG_TCNT, 32'hFFFF_FFFE);
        wr(IRQC_REG_TCTRL, 32'h1);
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (exp_tick_o) begin
                first = i;
                break;
            end
        end
        check("wrap_first_tick", 32'(first), 32'd6);
        wr(IRQC_REG_TCTRL, 32'h0);
        rd(IRQC_REG_TCNT, d);
        check("wrap_keeps_count", d, 32'd5);

        // Reset mid-run
        wr(IRQC_REG_EDGE, 32'h1);
        wr(IRQC_REG_ENABLE, 32'h1);
        irq_i = 32'h1;
        cyc(1);
        irq_i = 32'h0;
        cyc(4);
        check("mid_exp_before", exp_irq_o, 32'h1);
        wr(IRQC_REG_TCMP, 32'd9);
        wr(IRQC_REG_TCTRL, 32'h3);
        rd(IRQC_REG_TCTRL, d);
        check("mid_tctrl_before", d, 32'h3);
        rst_i = 1'b0;
        #1;
        check("mid_rst_exp", exp_irq_o, 32'h0);
        check("mid_rst_tick", {31'd0, exp_tick_o}, 32'd0);
        check("mid_rst_ready", {31'd0, bus_ready_o}, 32'd0);
        check("mid_rst_rdata", bus_rdata_o, 32'd0);
        cyc(2);
        rst_i = 1'b1;
        nt = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1);
            if (exp_tick_o) nt++;
        end
        check("post_rst_no_tick", 32'(nt), 32'd0);
        rd(IRQC_REG_TCTRL, d);
        check("post_rst_tctrl", d, 32'h0);
        rd(IRQC_REG_PENDING, d);
        check("post_rst_pending", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/urv_irq_ctrl.md
Name: urv_irq_ctrl

Overview:
- Interrupt source controller sitting on the peripheral bus, in front of the core's exception unit.
- Collects external interrupt lines, latches them as pending, and masks them with an enable register.
- Drives the exception unit's IRQ vector input (exp_irq_i) and timer tick input (exp_tick_i).
- Exposes a small word-addressed register file for enable, pending, claim and timer control.

Parameters:
- N_IRQ, 32, number of external interrupt lines (1..32); unused exp_irq_o bits tie to 0.
- SYNC_STAGES, 2, synchroniser depth on irq_i (min 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- irq_i  in  N_IRQ  external interrupt lines, asynchronous to clk_i.
- bus_addr_i  in  3  word address of register.
- bus_wdata_i  in  32  write data.
- bus_we_i  in  1  write strobe, single cycle.
- bus_re_i  in  1  read strobe, single cycle.
- bus_rdata_o  out  32  read data, valid while bus_ready_o=1.
- bus_ready_o  out  1  access-complete pulse.
- exp_irq_o  out  32  pending & enable, to the exception unit's exp_irq_i.
- exp_tick_o  out  1  one-cycle timer tick, to the exception unit's exp_tick_i.

Behaviour:
- Reset: all registers 0; bus_rdata_o=0, bus_ready_o=0, exp_irq_o=0, exp_tick_o=0; synchroniser flops 0.
- Register map (word address):
  - 0 PENDING: R; W1C.
  - 1 ENABLE: RW.
  - 2 EDGE: RW; 1 = rising-edge line, 0 = level line.
  - 3 CLAIM: R.
  - 4 TCNT: RW.
  - 5 TCMP: RW.
  - 6 TCTRL: bit0 run, bit1 autoreload; other bits read 0.
  - 7: reads 0, writes ignored.
- Input path: irq_i passes through SYNC_STAGES flops, then one extra flop for edge detect. Latency from an irq_i change to a pending update is SYNC_STAGES+1 cycles.
- Edge line:
  - Pending bit sets on a synced 0->1 transition.
  - Cleared by a PENDING W1C or by a CLAIM read selecting it.
  - A set and a clear in the same cycle: set wins.
- Level line:
  - Pending bit equals the synced level every cycle.
  - W1C and CLAIM have no effect on it.
- exp_irq_o is registered: exp_irq_o <= pending & enable, one cycle after pending/enable change. Bits >= N_IRQ are 0.
- CLAIM read:
  - Returns index+1 of the lowest-numbered bit of (pending & enable), or 0 if none.
  - If the selected line is an edge line, its pending bit clears in the same cycle as the read strobe.
- Timer:
  - When run=1, TCNT increments by 1 each cycle, wrapping 0xFFFFFFFF->0.
  - Compare hit when TCNT==TCMP and run=1: exp_tick_o=1 in the next cycle, for exactly one cycle.
  - On a hit with autoreload=1, TCNT loads 0 instead of incrementing. With autoreload=0, TCNT keeps counting.
  - A TCNT bus write in the same cycle as an increment: write wins.
  - run=0 freezes TCNT and suppresses ticks.
- Bus:
  - Accept a strobe in cycle N; bus_ready_o=1 and bus_rdata_o valid in cycle N+1. Register side effects occur at the end of cycle N.
  - bus_re_i and bus_we_i together: the write is performed and the read returns the pre-write value.
  - bus_rdata_o returns to 0 when bus_ready_o=0.
  - Back-to-back strobes every cycle are supported.
- Reset asserted mid-operation clears pending state, timer and outputs immediately (asynchronous). No tick and no spurious edge are generated on reset release.

Decomposition:
- Shared defs file (alongside the existing CSR/exception defines): register address constants IRQC_REG_PENDING..IRQC_REG_TCTRL, and TCTRL bit positions.
- One sub-module, urv_irq_timer: TCNT/TCMP/TCTRL plus tick generation, with its own write-enable inputs from the bus decoder.

Test Plan:
- Edge line: EDGE=0x1, ENABLE=0x1, pulse irq_i[0] high for 1 cycle -> PENDING=0x1 and exp_irq_o=0x1 after SYNC_STAGES+2 cycles. CLAIM read returns 1. Then PENDING=0 and exp_irq_o=0 on the following cycle.
- Level line: EDGE=0, ENABLE=0x4, hold irq_i[2]=1 -> exp_irq_o=0x4. Write PENDING=0x4 -> bit stays 1. Drop irq_i[2] -> exp_irq_o=0 after SYNC_STAGES+2 cycles.
- Priority and mask: lines 3 and 5 pending, ENABLE=0x20 -> CLAIM returns 6 and exp_irq_o=0x20. Set ENABLE=0x28 -> CLAIM returns 4.
- Set/clear race: edge line 1 rises in the same cycle as a W1C of 0x2 -> PENDING bit1 remains 1.
- Timer: TCMP=9, TCTRL=0x3 -> exp_tick_o pulses every 10 cycles, each pulse 1 cycle wide. With TCTRL=0x1, TCMP=3, TCNT=0xFFFFFFFE -> TCNT wraps to 0 with no tick until it reaches 3.
- Reset mid-run: assert rst_i while exp_irq_o=0x1 and the timer is running -> all outputs 0 immediately. After release, no tick occurs until TCTRL is rewritten.
